game_ctrl_fsm: RTL

Parametrised successor to the lab4 direction/win/lose state machine for the tile game.
- Converts level button inputs into single move commands.
- Drives the board datapath through a move/spawn handshake, then evaluates win/lose.
- Adds a move counter, one-deep press buffering and a handshake watchdog.
- Sits between the button debouncers and the board datapath/VGA status logic.

---
 rtl/game_ctrl_fsm_if.sv | 21 ++
 rtl/game_ctrl_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm_if.sv
// game_ctrl_fsm_if: button inputs, board move/spawn handshake and status outputs of the tile-game controller.
interface game_ctrl_fsm_if #(
    parameter int MOVE_CNT_W = 16
);
    logic up, down, left, right;
    logic win_in, lose_in, move_done, spawn_done;
    logic move_start, spawn_start, busy;
    logic win_state, lose_state, err_timeout;
    logic [1:0] dir;
    logic [2:0] state_o;
    logic [MOVE_CNT_W-1:0] move_count;

    modport master (
        output up, down, left, right, win_in, lose_in, move_done, spawn_done,
        input  move_start, dir, spawn_start, busy, state_o, win_state, lose_state, err_timeout, move_count
    );
    modport slave (
        input  up, down, left, right, win_in, lose_in, move_done, spawn_done,
        output move_start, dir, spawn_start, busy, state_o, win_state, lose_state, err_timeout, move_count
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: tile-game move controller with one-deep press buffer, saturating move counter and handshake watchdog.
// Optional GAME_IDLE_TIMEOUT_EN forces LOSE after IDLE_TIMEOUT idle cycles once at least one move has completed.
module game_ctrl_fsm #(
    parameter int MOVE_CNT_W   = 16,
    parameter int ACK_TIMEOUT  = 64,
    parameter int IDLE_TIMEOUT = 1000
) (
    input logic clk,
    input logic reset,
    game_ctrl_fsm_if.slave io_bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        SPAWN = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam int WD_W = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(ACK_TIMEOUT);

    state_t                r_state;
    logic [3:0]            r_btn_prev;
    logic [1:0]            r_dir, r_pend_dir;
    logic                  r_pend_v, r_move_start, r_spawn_start;
    logic [WD_W-1:0]       r_wd_cnt;
    logic [MOVE_CNT_W-1:0] r_move_count;
    logic [3:0]            w_btn, w_rise;
    logic [1:0]            w_press_dir;
    logic                  w_press, w_busy, w_wd_expired, w_idle_expired;

    assign w_btn        = {io_bus.right, io_bus.left, io_bus.down, io_bus.up};
    assign w_rise       = w_btn & ~r_btn_prev;
    assign w_press      = |w_rise;
    assign w_press_dir  = w_rise[0] ? 2'd0 : w_rise[1] ? 2'd1 : w_rise[2] ? 2'd2 : 2'd3;
    assign w_busy       = r_state inside {MOVE, SPAWN, CHECK};
    // The watchdog trips one cycle after the window closes, so done in the last allowed cycle still wins.
    assign w_wd_expired = (ACK_TIMEOUT != 0) && (r_wd_cnt >= WD_LIMIT);

`ifdef GAME_IDLE_TIMEOUT_EN
    localparam int IT_W = $clog2(IDLE_TIMEOUT + 1);
    logic [IT_W-1:0] r_idle_cnt;
    assign w_idle_expired = (32'(r_idle_cnt) + 32'd1 >= 32'(IDLE_TIMEOUT)) && (r_move_count != '0);
`else
    assign w_idle_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_btn_prev    <= '1;
            r_dir         <= '0;
            r_pend_dir    <= '0;
            r_pend_v      <= 1'b0;
            r_move_start  <= 1'b0;
            r_spawn_start <= 1'b0;
            r_wd_cnt      <= '0;
            r_move_count  <= '0;
`ifdef GAME_IDLE_TIMEOUT_EN
            r_idle_cnt    <= '0;
`endif
        end else begin
            r_btn_prev    <= w_btn;
            r_move_start  <= 1'b0;
            r_spawn_start <= 1'b0;
            if (w_busy && w_press && !r_pend_v) begin
                r_pend_v   <= 1'b1;
                r_pend_dir <= w_press_dir;
            end
            case (r_state)
                IDLE: begin
`ifdef GAME_IDLE_TIMEOUT_EN
                    r_idle_cnt <= r_idle_cnt + 1'b1;
`endif
                    if (r_pend_v || w_press) begin
                        r_state      <= MOVE;
                        r_dir        <= r_pend_v ? r_pend_dir : w_press_dir;
                        r_pend_v     <= 1'b0;
                        r_move_start <= 1'b1;
                        r_wd_cnt     <= '0;
                    end else if (w_idle_expired) begin
                        r_state <= LOSE;
                    end
                end
                MOVE: begin
                    if (w_wd_expired) begin
                        r_state <= ERROR;
                    end else if (io_bus.move_done) begin
                        r_state       <= SPAWN;
                        r_spawn_start <= 1'b1;
                        r_wd_cnt      <= '0;
                        r_move_count  <= (r_move_count == '1) ? r_move_count : r_move_count + 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                SPAWN: begin
                    if (w_wd_expired) r_state <= ERROR;
                    else if (io_bus.spawn_done) r_state <= CHECK;
                    else r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                CHECK: begin
                    if (io_bus.win_in) begin
                        r_state <= WIN;
                    end else if (io_bus.lose_in) begin
                        r_state <= LOSE;
                    end else if (r_pend_v) begin
                        // A press landing in this same cycle refills the buffer being consumed.
                        r_state      <= MOVE;
                        r_dir        <= r_pend_dir;
                        r_pend_v     <= w_press;
                        r_pend_dir   <= w_press_dir;
                        r_move_start <= 1'b1;
                        r_wd_cnt     <= '0;
                    end else begin
                        r_state <= IDLE;
`ifdef GAME_IDLE_TIMEOUT_EN
                        r_idle_cnt <= '0;
`endif
                    end
                end
                WIN, LOSE, ERROR: r_state <= r_state;
                default: begin
                    r_state <= IDLE;
`ifdef GAME_IDLE_TIMEOUT_EN
                    r_idle_cnt <= '0;
`endif
                end
            endcase
        end
    end

    assign io_bus.move_start  = r_move_start;
    assign io_bus.spawn_start = r_spawn_start;
    assign io_bus.dir         = r_dir;
    assign io_bus.busy        = w_busy;
    assign io_bus.state_o     = r_state;
    assign io_bus.win_state   = (r_state == WIN);
    assign io_bus.lose_state  = (r_state == LOSE);
    assign io_bus.err_timeout = (r_state == ERROR);
    assign io_bus.move_count  = r_move_count;
endmodule
